// File: rtl/ecc_scrub_pkg.sv
// Shared types and default widths for the ECC background scrubber.
package ecc_scrub_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 107;
    localparam int unsigned DEF_PARITY_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_NEXT
    } scrub_state_e;

endpackage

// File: rtl/ecc_scrub_sat_cnt.sv
// Saturating event counter; clear wins over a same-cycle increment.
module ecc_scrub_sat_cnt #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/ecc_107_scrub_ctrl.sv
// Background ECC scrubber: walks the RAM in idle slots, writes back corrected
// single-bit errors and reports double-bit errors and checker faults.
module ecc_107_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned PARITY_WIDTH = DEF_PARITY_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scrub_en,
    input  logic [15:0]             scrub_interval,
    input  logic                    cnt_clr,
    input  logic                    func_req,
    input  logic                    func_we,
    input  logic [ADDR_WIDTH-1:0]   func_addr,
    output logic                    ram_cs,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [PARITY_WIDTH-1:0] ram_wparity,
    input  logic [DATA_WIDTH-1:0]   chk_data,
    input  logic [PARITY_WIDTH-1:0] chk_parity,
    input  logic                    chk_sbit_err,
    input  logic                    chk_dbit_err,
    input  logic                    chk_fault,
    output logic                    scrub_busy,
    output logic                    pass_done,
    output logic                    dbit_irq,
    output logic                    fault_irq,
    output logic [ADDR_WIDTH-1:0]   dbit_addr,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    scrub_state_e              r_state;
    logic [ADDR_WIDTH-1:0]     r_ptr;
    logic [15:0]               r_ival;
    logic [LAT_W-1:0]          r_lat;
    logic                      r_cancel;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [PARITY_WIDTH-1:0]   r_wparity;
    logic                      r_pass_done;
    logic                      r_dbit_irq;
    logic                      r_fault_irq;
    logic [ADDR_WIDTH-1:0]     r_dbit_addr;

    logic                      w_cs;
    logic                      w_collide;
    logic                      w_sample;
    logic                      w_last;
    logic                      w_sbit_inc;
    logic                      w_dbit_inc;
    logic                      w_fault_inc;
    scrub_state_e              w_after;

    always_comb begin
        w_cs        = ((r_state == ST_READ) || (r_state == ST_WRITE)) && !func_req;
        w_collide   = func_req && func_we && (func_addr == r_ptr);
        w_sample    = (r_state == ST_CHECK) && (r_lat == LAT_W'(RD_LAT - 1));
        w_last      = (r_ptr == ADDR_WIDTH'(DEPTH - 1));
        // Fault outranks dbit, which outranks sbit; sbit still counts when cancelled.
        w_fault_inc = w_sample && chk_fault;
        w_dbit_inc  = w_sample && !chk_fault && chk_dbit_err;
        w_sbit_inc  = w_sample && !chk_fault && !chk_dbit_err && chk_sbit_err;
        w_after     = (scrub_interval == 16'd0) ? ST_READ : ST_WAIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_ival      <= '0;
            r_lat       <= '0;
            r_cancel    <= 1'b0;
            r_wdata     <= '0;
            r_wparity   <= '0;
            r_pass_done <= 1'b0;
            r_dbit_irq  <= 1'b0;
            r_fault_irq <= 1'b0;
            r_dbit_addr <= '0;
        end else begin
            r_pass_done <= 1'b0;
            r_dbit_irq  <= 1'b0;
            r_fault_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (scrub_en) begin
                        r_ival  <= '0;
                        r_state <= w_after;
                    end
                end
                ST_WAIT: begin
                    if ((r_ival + 16'd1) >= scrub_interval) begin
                        r_state <= ST_READ;
                    end else begin
                        r_ival <= r_ival + 16'd1;
                    end
                end
                ST_READ: begin
                    if (!func_req) begin
                        r_lat    <= '0;
                        r_cancel <= 1'b0;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_sample) begin
                        if (chk_fault) begin
                            r_fault_irq <= 1'b1;
                            r_dbit_addr <= r_ptr;
                            r_state     <= ST_NEXT;
                        end else if (chk_dbit_err) begin
                            r_dbit_irq  <= 1'b1;
                            r_dbit_addr <= r_ptr;
                            r_state     <= ST_NEXT;
                        end else if (chk_sbit_err && !(r_cancel || w_collide)) begin
                            r_wdata   <= chk_data;
                            r_wparity <= chk_parity;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else begin
                        r_lat <= r_lat + 1'b1;
                        if (w_collide) begin
                            r_cancel <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // The write itself happens combinationally in the cycle func_req is low.
                    if (!func_req || w_collide) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_ptr       <= w_last ? '0 : r_ptr + 1'b1;
                    r_pass_done <= w_last;
                    r_ival      <= '0;
                    r_state     <= scrub_en ? w_after : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ecc_scrub_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sbit_inc),
        .clr   (cnt_clr),
        .cnt   (sbit_cnt)
    );

    ecc_scrub_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_dbit_inc),
        .clr   (cnt_clr),
        .cnt   (dbit_cnt)
    );

    ecc_scrub_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_fault_inc),
        .clr   (cnt_clr),
        .cnt   (fault_cnt)
    );

    assign ram_cs      = w_cs;
    assign ram_we      = w_cs && (r_state == ST_WRITE);
    assign ram_addr    = w_cs ? r_ptr : '0;
    assign ram_wdata   = r_wdata;
    assign ram_wparity = r_wparity;
    assign scrub_busy  = (r_state != ST_IDLE);
    assign pass_done   = r_pass_done;
    assign dbit_irq    = r_dbit_irq;
    assign fault_irq   = r_fault_irq;
    assign dbit_addr   = r_dbit_addr;

endmodule

// File: tb/tb_ecc_107_scrub_ctrl.sv
// Scoreboard bench for ecc_107_scrub_ctrl: expected RAM accesses and interrupt
// events are queued per scenario and popped by a negedge monitor.
module tb_ecc_107_scrub_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scrub_en = 1'b0;
    logic [15:0]  scrub_interval = '0;
    logic         cnt_clr = 1'b0;
    logic         func_req = 1'b0;
    logic         func_we = 1'b0;
    logic [7:0]   func_addr = '0;
    logic         ram_cs, ram_we;
    logic [7:0]   ram_addr;
    logic [106:0] ram_wdata;
    logic [7:0]   ram_wparity;
    logic [106:0] chk_data;
    logic [7:0]   chk_parity;
    logic         chk_sbit_err, chk_dbit_err, chk_fault;
    logic         scrub_busy, pass_done, dbit_irq, fault_irq;
    logic [7:0]   dbit_addr;
    logic [15:0]  sbit_cnt, dbit_cnt, fault_cnt;

    logic         sc_inc = 1'b0, sc_clr = 1'b0;
    logic [3:0]   sc_cnt;

    ecc_107_scrub_ctrl #(.DEPTH(4), .RD_LAT(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
        .cnt_clr(cnt_clr), .func_req(func_req), .func_we(func_we), .func_addr(func_addr),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wparity(ram_wparity), .chk_data(chk_data), .chk_parity(chk_parity),
        .chk_sbit_err(chk_sbit_err), .chk_dbit_err(chk_dbit_err), .chk_fault(chk_fault),
        .scrub_busy(scrub_busy), .pass_done(pass_done), .dbit_irq(dbit_irq),
        .fault_irq(fault_irq), .dbit_addr(dbit_addr), .sbit_cnt(sbit_cnt),
        .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt)
    );

    ecc_scrub_sat_cnt #(.CNT_WIDTH(4)) u_sc (
        .clk(clk), .rst_n(rst_n), .inc(sc_inc), .clr(sc_clr), .cnt(sc_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    int n_chk = 0;
    int n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ECC checker: answers for the address read one cycle earlier.
    logic [106:0] data_tab [4];
    logic [7:0]   par_tab  [4];
    logic         sb_tab   [4];
    logic         db_tab   [4];
    logic         ft_tab   [4];
    logic [1:0]   last_rd = '0;
    always @(posedge clk) if (ram_cs && !ram_we) last_rd <= ram_addr[1:0];
    assign chk_data     = data_tab[last_rd];
    assign chk_parity   = par_tab[last_rd];
    assign chk_sbit_err = sb_tab[last_rd];
    assign chk_dbit_err = db_tab[last_rd];
    assign chk_fault    = ft_tab[last_rd];

    typedef struct {
        logic         we;
        logic [7:0]   addr;
        logic [106:0] wdata;
        logic [7:0]   wpar;
        int           cyc;
    } acc_t;
    typedef struct {
        int         kind;
        logic [7:0] addr;
        int         cyc;
    } evt_t;
    localparam int EV_PASS = 0, EV_DBIT = 1, EV_FAULT = 2;

    acc_t acc_q[$];
    evt_t evt_q[$];
    acc_t m_acc;
    evt_t m_evt;

    logic [106:0] D1, D2, DBAD;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_acc(input logic we, input logic [7:0] a, input logic [106:0] d,
                            input logic [7:0] p, input int c);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d; e.wpar = p; e.cyc = c;
        acc_q.push_back(e);
    endtask

    task automatic push_evt(input int k, input logic [7:0] a, input int c);
        evt_t e;
        e.kind = k; e.addr = a; e.cyc = c;
        evt_q.push_back(e);
    endtask

    task automatic start(input logic [15:0] ival);
        scrub_interval = ival;
        scrub_en = 1'b1;
        base = cyc;
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 4; i++) begin
            data_tab[i] = DBAD;
            par_tab[i]  = 8'hFF;
            sb_tab[i]   = 1'b0;
            db_tab[i]   = 1'b0;
            ft_tab[i]   = 1'b0;
        end
    endtask

    task automatic drained(input string tag);
        chk({tag, "_acc_q_empty"}, 128'(acc_q.size()), 128'd0);
        chk({tag, "_evt_q_empty"}, 128'(evt_q.size()), 128'd0);
        chk({tag, "_idle"}, 128'(scrub_busy), 128'd0);
    endtask

    always @(negedge clk) begin
        chk("cs_and_func_req", 128'(ram_cs & func_req), 128'd0);
        if (ram_cs) begin
            if (acc_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL unexpected_access: we=%0b addr=%0d at cycle %0d, none required",
                         ram_we, ram_addr, cyc - base);
            end else begin
                m_acc = acc_q.pop_front();
                chk("acc_we",   128'(ram_we),   128'(m_acc.we));
                chk("acc_addr", 128'(ram_addr), 128'(m_acc.addr));
                chk("acc_cycle", 128'(cyc - base), 128'(m_acc.cyc));
                if (m_acc.we) begin
                    chk("acc_wdata",   128'(ram_wdata),   128'(m_acc.wdata));
                    chk("acc_wparity", 128'(ram_wparity), 128'(m_acc.wpar));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if ((k == EV_PASS && pass_done) || (k == EV_DBIT && dbit_irq) ||
                (k == EV_FAULT && fault_irq)) begin
                if (evt_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_event: kind=%0d at cycle %0d, none required",
                             k, cyc - base);
                end else begin
                    m_evt = evt_q.pop_front();
                    chk("evt_kind",  128'(k),          128'(m_evt.kind));
                    chk("evt_cycle", 128'(cyc - base), 128'(m_evt.cyc));
                    if (k != EV_PASS) chk("evt_dbit_addr", 128'(dbit_addr), 128'(m_evt.addr));
                end
            end
        end
    end

    initial begin
        D1   = {3'b010, {13{8'h5A}}};
        D2   = {3'b101, {13{8'hC3}}};
        DBAD = '1;
        clear_tabs();

        tick(3);
        chk("rst_busy",    128'(scrub_busy), 128'd0);
        chk("rst_cs",      128'(ram_cs),     128'd0);
        chk("rst_wdata",   128'(ram_wdata),  128'd0);
        chk("rst_sbit_cnt", 128'(sbit_cnt),  128'd0);
        chk("rst_irqs",    128'({pass_done, dbit_irq, fault_irq}), 128'd0);
        rst_n = 1'b1;
        tick(2);

        // Clean pass, interval 2: one read every 5 cycles, no writes.
        push_acc(0, 0, '0, '0, 3);
        push_acc(0, 1, '0, '0, 8);
        push_acc(0, 2, '0, '0, 13);
        push_acc(0, 3, '0, '0, 18);
        push_evt(EV_PASS, 0, 21);
        start(16'd2);
        tick(18); scrub_en = 1'b0;
        tick(8);
        drained("clean");
        chk("clean_cnts", 128'({sbit_cnt, dbit_cnt, fault_cnt}), 128'd0);

        // Single-bit error at addr 2, interval 0.
        sb_tab[2] = 1'b1; data_tab[2] = D1; par_tab[2] = 8'h3C;
        push_acc(0, 0, '0, '0, 1);
        push_acc(0, 1, '0, '0, 4);
        push_acc(0, 2, '0, '0, 7);
        push_acc(1, 2, D1, 8'h3C, 9);
        push_acc(0, 3, '0, '0, 11);
        push_evt(EV_PASS, 0, 14);
        start(16'd0);
        tick(11); scrub_en = 1'b0;
        tick(6);
        drained("sbit");
        chk("sbit_cnt_1", 128'(sbit_cnt), 128'd1);
        clear_tabs();

        // Double-bit at addr 1; fault together with sbit at addr 3 (fault wins).
        db_tab[1] = 1'b1; ft_tab[3] = 1'b1; sb_tab[3] = 1'b1;
        push_acc(0, 0, '0, '0, 2);
        push_acc(0, 1, '0, '0, 6);
        push_acc(0, 2, '0, '0, 10);
        push_acc(0, 3, '0, '0, 14);
        push_evt(EV_DBIT, 1, 8);
        push_evt(EV_FAULT, 3, 16);
        push_evt(EV_PASS, 0, 17);
        start(16'd1);
        tick(14); scrub_en = 1'b0;
        tick(6);
        drained("dbit_fault");
        chk("dbit_cnt_1",  128'(dbit_cnt),  128'd1);
        chk("fault_cnt_1", 128'(fault_cnt), 128'd1);
        chk("sbit_cnt_still_1", 128'(sbit_cnt), 128'd1);
        chk("dbit_addr_3", 128'(dbit_addr), 128'd3);
        clear_tabs();

        // Functional port held for 10 cycles over READ and over WRITE.
        sb_tab[0] = 1'b1; data_tab[0] = D2; par_tab[0] = 8'hA5;
        push_acc(0, 0, '0, '0, 10);
        push_acc(1, 0, D2, 8'hA5, 22);
        start(16'd0);
        func_req = 1'b1; func_we = 1'b0; func_addr = 8'd0;
        tick(10); func_req = 1'b0;
        tick(2);  func_req = 1'b1; scrub_en = 1'b0;
        tick(10); func_req = 1'b0;
        tick(5);
        drained("stall");
        chk("sbit_cnt_2", 128'(sbit_cnt), 128'd2);
        clear_tabs();

        // Functional write to addr 3 during CHECK cancels the writeback.
        sb_tab[3] = 1'b1; data_tab[3] = D1; par_tab[3] = 8'h3C;
        push_acc(0, 1, '0, '0, 1);
        push_acc(0, 2, '0, '0, 4);
        push_acc(0, 3, '0, '0, 7);
        push_evt(EV_PASS, 0, 10);
        start(16'd0);
        tick(7); scrub_en = 1'b0;
        tick(1); func_req = 1'b1; func_we = 1'b1; func_addr = 8'd3;
        tick(1); func_req = 1'b0; func_we = 1'b0;
        tick(5);
        drained("collide");
        chk("sbit_cnt_3", 128'(sbit_cnt), 128'd3);
        clear_tabs();

        // cnt_clr coincident with an sbit increment.
        sb_tab[0] = 1'b1; data_tab[0] = D2; par_tab[0] = 8'hA5;
        push_acc(0, 0, '0, '0, 1);
        push_acc(1, 0, D2, 8'hA5, 3);
        start(16'd0);
        tick(2); cnt_clr = 1'b1;
        tick(1); cnt_clr = 1'b0; scrub_en = 1'b0;
        tick(4);
        drained("clr");
        chk("clr_cnts", 128'({sbit_cnt, dbit_cnt, fault_cnt}), 128'd0);
        clear_tabs();

        // Reset asserted while the writeback is on the bus.
        sb_tab[1] = 1'b1; data_tab[1] = D1; par_tab[1] = 8'h3C;
        push_acc(0, 1, '0, '0, 1);
        push_acc(1, 1, D1, 8'h3C, 3);
        start(16'd0);
        tick(3); rst_n = 1'b0; scrub_en = 1'b0;
        tick(1);
        chk("rst2_busy",    128'(scrub_busy), 128'd0);
        chk("rst2_bus",     128'({ram_cs, ram_we, ram_addr}), 128'd0);
        chk("rst2_wdata",   128'({ram_wdata, ram_wparity}), 128'd0);
        chk("rst2_cnts",    128'({sbit_cnt, dbit_cnt, fault_cnt}), 128'd0);
        chk("rst2_dbit_addr", 128'(dbit_addr), 128'd0);
        rst_n = 1'b1;
        tick(6);
        drained("rst_mid_write");
        clear_tabs();

        // Saturation on a narrow counter instance.
        sc_inc = 1'b1;
        tick(15);
        chk("sat_reach_max", 128'(sc_cnt), 128'hF);
        tick(2);
        chk("sat_hold_max", 128'(sc_cnt), 128'hF);
        sc_clr = 1'b1;
        tick(1);
        chk("sat_clr_wins", 128'(sc_cnt), 128'd0);
        sc_clr = 1'b0; sc_inc = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_107_scrub_ctrl.md
Name: ecc_107_scrub_ctrl

Overview:
Background scrubber for a 107-bit-data / 8-bit-parity ECC-protected RAM.
- Periodically walks every address using spare RAM cycles.
- Sends each read through the external ECC checker (the dual-instance fault-detecting corrector).
- Writes corrected data back on a single-bit error; logs double-bit errors and checker-disagreement faults.
- Sits beside the FIFO/RAM wrapper; the functional port always has priority.

Parameters:
DATA_WIDTH, 107, RAM data width
PARITY_WIDTH, 8, RAM parity width
ADDR_WIDTH, 8, RAM address width
DEPTH, 256, number of words scrubbed per pass (≤ 2^ADDR_WIDTH)
RD_LAT, 1, RAM read latency plus checker latency in cycles (≥1)
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
scrub_en  in  1  enable scrubbing
scrub_interval  in  16  idle cycles between consecutive addresses
cnt_clr  in  1  clear all counters (1-cycle pulse)
func_req  in  1  functional RAM access this cycle (priority)
func_we  in  1  functional access is a write
func_addr  in  ADDR_WIDTH  functional access address
ram_cs  out  1  scrubber RAM chip select (never high with func_req)
ram_we  out  1  scrubber write enable
ram_addr  out  ADDR_WIDTH  scrubber address
ram_wdata  out  DATA_WIDTH  writeback data
ram_wparity  out  PARITY_WIDTH  writeback parity
chk_data  in  DATA_WIDTH  corrected data from checker
chk_parity  in  PARITY_WIDTH  parity regenerated for chk_data
chk_sbit_err  in  1  single-bit error flag
chk_dbit_err  in  1  double-bit error flag
chk_fault  in  1  checker self-compare fault
scrub_busy  out  1  FSM not in IDLE
pass_done  out  1  1-cycle pulse when last address is completed
dbit_irq  out  1  1-cycle pulse on double-bit error
fault_irq  out  1  1-cycle pulse on checker fault
dbit_addr  out  ADDR_WIDTH  address of most recent dbit/fault event
sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH each  saturating counters

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; address pointer, interval counter and all counters are cleared.
  - All outputs are 0.
  - Reset mid-operation abandons any pending writeback.
- States and transitions:
  - IDLE → WAIT when scrub_en=1.
  - WAIT counts scrub_interval cycles (0 means skip WAIT), then → READ.
  - READ: ram_cs=1, ram_we=0, ram_addr=ptr, only in a cycle with func_req=0; otherwise stalls in READ. Issue → CHECK.
  - CHECK: waits RD_LAT cycles, then samples the chk_* inputs exactly once.
    - chk_fault=1: fault_cnt++, fault_irq, dbit_addr=ptr, no writeback (checker output untrusted); fault takes precedence over the sbit/dbit flags.
    - dbit=1: dbit_cnt++, dbit_irq, dbit_addr=ptr, no writeback.
    - sbit=1: sbit_cnt++, latch chk_data/chk_parity → WRITE.
    - Otherwise → NEXT.
  - WRITE: ram_cs=1, ram_we=1 with the latched data, only when func_req=0; otherwise holds → NEXT.
  - NEXT: ptr++; on ptr==DEPTH-1 wrap to 0 and pulse pass_done. Then → WAIT if scrub_en=1, else → IDLE.
- Collision rule: a functional write with func_addr==ptr while in CHECK or WRITE cancels the pending writeback (fresh data must not be overwritten). The sbit count is still recorded.
- scrub_en dropped mid-address: the current address completes through NEXT, then IDLE. ptr is retained, so re-enable resumes.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment.
  - Counters are not cleared by scrub_en.
- ram_wdata/ram_wparity are registered; ram_cs/ram_we/ram_addr are combinational from state and func_req.
- Invariant: ram_cs & func_req == 0 in every cycle.

Decomposition:
- Shared package ecc_scrub_pkg: FSM state enum (IDLE, WAIT, READ, CHECK, WRITE, NEXT) and default widths (DATA/PARITY/ADDR).
- Sub-module ecc_scrub_sat_cnt (CNT_WIDTH, inc, clr, sync active-low reset), instantiated three times.

Test Plan:
- Clean RAM, DEPTH=4, interval=2, RD_LAT=1, no func_req → reads at addresses 0,1,2,3 every 5 cycles (interval 2 + READ + CHECK + NEXT); pass_done pulses once after addr 3; no writes; all counters stay 0.
- chk_sbit_err=1 at addr 2, chk_data=107'h5A…, chk_parity=8'h3C → one write cycle at addr 2 with that data and parity; sbit_cnt=1.
- chk_dbit_err=1 at addr 1 → dbit_irq pulses one cycle, dbit_addr=1, dbit_cnt=1, no write. Repeat with chk_fault=1 → fault_cnt=1, fault_irq pulses, no write.
- func_req held high for 10 cycles during READ and WRITE → scrubber stalls; ram_cs stays 0 throughout; the operation completes on the first cycle func_req=0.
- sbit on addr 3, then a functional write to addr 3 during CHECK → no writeback; sbit_cnt=1.
- Counters forced to 16'hFFFF plus another sbit → counter stays FFFF; cnt_clr in the same cycle as an increment → 0; rst_n low mid-WRITE → IDLE next cycle with all outputs 0.
